// File: rtl/bnn_feed_ctrl.sv
// bnn_feed_ctrl: sequences one layer-row job for a binary NN array. It buffers
//   O_CH host weights, bursts them into the array, clears the psums, streams
//   activations, waits for the array pipeline to drain, then pops O_CH rows.
// Latency: accepted activation -> data_out/in_valid_out one cycle later;
//   pop cycle k -> m_sum_out/m_ch_out/m_valid_out one cycle later.
// Backpressure: s_ready_out is high only while filling weights or feeding
//   activations. The array strobes and m_* outputs cannot be stalled.
//
// Optional feature: define FEED_CTRL_WEIGHT_REUSE_EN to add reuse_weight_in.
//   A job started with reuse_weight_in=1 skips the weight fill and burst and
//   keeps the weights already held in the array.
//
// Ports:
//   clk_in, rst_in            clock; asynchronous active-high reset
//   start_in, num_act_in      job start and its activation count (latched)
//   reuse_weight_in           (optional) skip the weight load for this job
//   s_data_in/_valid_in/_ready_out   host weight/activation stream
//   data_out, load_weight_out, in_valid_out, pop_out, array_rst_n_out
//                             registered array-side controls
//   array_sum_in              sign bits read from the array while popping
//   m_sum_out, m_ch_out, m_valid_out  captured sign bits and their channel
//   busy_out, done_out        job active; one-cycle pulse at job end
module bnn_feed_ctrl #(
  parameter int O_CH           = 64,
  parameter int OUT_ROW_LENGTH = 4,
  parameter int DRAIN_CYCLES   = 66
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
`ifdef FEED_CTRL_WEIGHT_REUSE_EN
  input  logic                      reuse_weight_in,
`endif
  input  logic [7:0]                num_act_in,
  input  logic [8:0]                s_data_in,
  input  logic                      s_valid_in,
  output logic                      s_ready_out,
  output logic [8:0]                data_out,
  output logic                      load_weight_out,
  output logic                      in_valid_out,
  output logic                      pop_out,
  output logic                      array_rst_n_out,
  input  logic [OUT_ROW_LENGTH-1:0] array_sum_in,
  output logic [OUT_ROW_LENGTH-1:0] m_sum_out,
  output logic [5:0]                m_ch_out,
  output logic                      m_valid_out,
  output logic                      busy_out,
  output logic                      done_out
);

  localparam int CW = $clog2(O_CH + 1);
  localparam int IW = (O_CH > 1) ? $clog2(O_CH) : 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 2);

  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(O_CH - 1);
  localparam logic [CW-1:0] FULL_IDX  = CW'(O_CH);
  localparam logic [DW-1:0] D_ONE     = DW'(1);
  localparam logic [DW-1:0] DRAIN_END = DW'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    W_FILL,
    W_BURST,
    CLEAR,
    FEED,
    DRAIN,
    POP
  } state_t;

  state_t        state;
  logic [CW-1:0] idx;        // fill write pointer, then burst read pointer
  logic [CW-1:0] k;          // pop index
  logic [7:0]    num_act;
  logic [7:0]    act_cnt;
  logic [DW-1:0] drain_cnt;
  logic [8:0]    wbuf [O_CH];

  logic          accept;
  logic [8:0]    first_w;

  assign accept = s_valid_in & s_ready_out;

  // The burst starts on the same edge that writes the last entry; with a
  // single-entry buffer that entry is the word on the bus right now.
  assign first_w = (O_CH == 1) ? s_data_in : wbuf[0];

  // Weight storage needs no reset: every job that reads it refills it first.
  always_ff @(posedge clk_in) begin
    if (state == W_FILL && accept) begin
      wbuf[idx[IW-1:0]] <= s_data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      idx             <= '0;
      k               <= '0;
      num_act         <= '0;
      act_cnt         <= '0;
      drain_cnt       <= '0;
      s_ready_out     <= 1'b0;
      data_out        <= '0;
      load_weight_out <= 1'b0;
      in_valid_out    <= 1'b0;
      pop_out         <= 1'b0;
      array_rst_n_out <= 1'b0;
      m_sum_out       <= '0;
      m_ch_out        <= '0;
      m_valid_out     <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
    end else begin
      // Strobes are single-cycle; each state re-asserts what it needs.
      data_out        <= '0;
      load_weight_out <= 1'b0;
      in_valid_out    <= 1'b0;
      pop_out         <= 1'b0;
      m_valid_out     <= 1'b0;
      done_out        <= 1'b0;
      array_rst_n_out <= 1'b1;

      case (state)
        IDLE: begin
          if (start_in) begin
            num_act  <= num_act_in;
            act_cnt  <= '0;
            busy_out <= 1'b1;
`ifdef FEED_CTRL_WEIGHT_REUSE_EN
            if (reuse_weight_in) begin
              state           <= CLEAR;
              array_rst_n_out <= 1'b0;
            end else begin
              state       <= W_FILL;
              s_ready_out <= 1'b1;
            end
`else
            state       <= W_FILL;
            s_ready_out <= 1'b1;
`endif
          end
        end

        W_FILL: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              s_ready_out     <= 1'b0;
              state           <= W_BURST;
              load_weight_out <= 1'b1;
              data_out        <= first_w;
              idx             <= C_ONE;
            end else begin
              idx <= idx + C_ONE;
            end
          end
        end

        W_BURST: begin
          if (idx == FULL_IDX) begin
            idx             <= '0;
            state           <= CLEAR;
            array_rst_n_out <= 1'b0;
          end else begin
            load_weight_out <= 1'b1;
            data_out        <= wbuf[idx[IW-1:0]];
            idx             <= idx + C_ONE;
          end
        end

        CLEAR: begin
          if (num_act == 8'd0) begin
            // No activations: the clear cycle is the last array activity,
            // so the cycle after it is already the first drain cycle.
            state     <= DRAIN;
            drain_cnt <= D_ONE;
          end else begin
            state       <= FEED;
            s_ready_out <= 1'b1;
          end
        end

        FEED: begin
          if (accept) begin
            in_valid_out <= 1'b1;
            data_out     <= s_data_in;
            act_cnt      <= act_cnt + 8'd1;
            if (act_cnt + 8'd1 == num_act) begin
              state       <= DRAIN;
              s_ready_out <= 1'b0;
              // The first DRAIN cycle carries the last in_valid_out and is
              // not counted as a drain cycle.
              drain_cnt   <= '0;
            end
          end
        end

        DRAIN: begin
          if (drain_cnt >= DRAIN_END) begin
            state     <= POP;
            pop_out   <= 1'b1;
            k         <= '0;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + D_ONE;
          end
        end

        POP: begin
          // array_sum_in belongs to the pop being issued this cycle.
          m_valid_out <= 1'b1;
          m_sum_out   <= array_sum_in;
          m_ch_out    <= 6'(k);
          if (k == LAST_IDX) begin
            state    <= IDLE;
            k        <= '0;
            idx      <= '0;
            act_cnt  <= '0;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end else begin
            k       <= k + C_ONE;
            pop_out <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_feed_ctrl.sv
// Bench for bnn_feed_ctrl: directed job sequence with randomized weights,
// activations, valid gaps and array sign bits; a negedge monitor records all
// array-side activity and each job is compared against its expected timeline.
module tb_bnn_feed_ctrl;

  localparam int O_CH  = 64;
  localparam int ORL   = 4;
  localparam int DRAIN = 66;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b1;
  logic           start_in = 1'b0;
`ifdef FEED_CTRL_WEIGHT_REUSE_EN
  logic           reuse_weight_in = 1'b0;
`endif
  logic [7:0]     num_act_in = '0;
  logic [8:0]     s_data_in = '0;
  logic           s_valid_in = 1'b0;
  logic           s_ready_out;
  logic [8:0]     data_out;
  logic           load_weight_out;
  logic           in_valid_out;
  logic           pop_out;
  logic           array_rst_n_out;
  logic [ORL-1:0] array_sum_in = '0;
  logic [ORL-1:0] m_sum_out;
  logic [5:0]     m_ch_out;
  logic           m_valid_out;
  logic           busy_out;
  logic           done_out;

  bnn_feed_ctrl #(.O_CH(O_CH), .OUT_ROW_LENGTH(ORL), .DRAIN_CYCLES(DRAIN)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
`ifdef FEED_CTRL_WEIGHT_REUSE_EN
    .reuse_weight_in (reuse_weight_in),
`endif
    .num_act_in      (num_act_in),
    .s_data_in       (s_data_in),
    .s_valid_in      (s_valid_in),
    .s_ready_out     (s_ready_out),
    .data_out        (data_out),
    .load_weight_out (load_weight_out),
    .in_valid_out    (in_valid_out),
    .pop_out         (pop_out),
    .array_rst_n_out (array_rst_n_out),
    .array_sum_in    (array_sum_in),
    .m_sum_out       (m_sum_out),
    .m_ch_out        (m_ch_out),
    .m_valid_out     (m_valid_out),
    .busy_out        (busy_out),
    .done_out        (done_out)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int viol = 0;
  int timeouts = 0;

  // Monitor records: cycle stamps and data of every array-side event.
  int             lw_cyc[$];
  logic [8:0]     lw_dat[$];
  int             iv_cyc[$];
  logic [8:0]     iv_dat[$];
  int             clr_cyc[$];
  int             pop_cyc[$];
  logic [ORL-1:0] pop_sum[$];
  int             mv_cyc[$];
  int             mv_ch[$];
  logic [ORL-1:0] mv_sum[$];
  int             done_cyc[$];

  // Reference: what the host sent, and when each activation was accepted.
  logic [8:0]     exp_w[$];
  logic [8:0]     exp_a[$];
  int             acc_cyc[$];

  initial forever #5 clk_in = ~clk_in;

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // Array sign bits change shortly after every edge, so each pop cycle
  // presents a fresh random value.
  initial forever begin
    @(posedge clk_in);
    #2 array_sum_in = ORL'($urandom);
  end

  initial forever begin
    @(negedge clk_in);
    if (!rst_in) begin
      if (load_weight_out) begin lw_cyc.push_back(cyc); lw_dat.push_back(data_out); end
      if (in_valid_out) begin iv_cyc.push_back(cyc); iv_dat.push_back(data_out); end
      if (!array_rst_n_out) clr_cyc.push_back(cyc);
      if (pop_out) begin pop_cyc.push_back(cyc); pop_sum.push_back(array_sum_in); end
      if (m_valid_out) begin
        mv_cyc.push_back(cyc); mv_ch.push_back(int'(m_ch_out)); mv_sum.push_back(m_sum_out);
      end
      if (done_out) done_cyc.push_back(cyc);
      if (int'(load_weight_out) + int'(in_valid_out) + int'(pop_out) > 1) viol++;
      if (!load_weight_out && !in_valid_out && data_out != 9'd0) viol++;
      if (s_ready_out && (load_weight_out || pop_out || !busy_out)) viol++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, observed no end expected end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    lw_cyc.delete(); lw_dat.delete(); iv_cyc.delete(); iv_dat.delete();
    clr_cyc.delete(); pop_cyc.delete(); pop_sum.delete();
    mv_cyc.delete(); mv_ch.delete(); mv_sum.delete(); done_cyc.delete();
    exp_w.delete(); exp_a.delete(); acc_cyc.delete();
    viol = 0;
    timeouts = 0;
  endtask

  // Called at a negedge; returns at the negedge after the word was taken.
  // acc is the cycle in which the word's effect is first visible.
  task automatic push_word(input logic [8:0] w, input int gap, output int acc);
    int guard;
    if (gap > 0) begin
      s_valid_in = 1'b0;
      repeat (gap) @(negedge clk_in);
    end
    s_data_in  = w;
    s_valid_in = 1'b1;
    guard = 0;
    while (!s_ready_out && guard < 2000) begin
      @(negedge clk_in);
      guard++;
    end
    if (!s_ready_out) begin
      acc = -1;
      timeouts++;
    end else begin
      acc = cyc + 1;
    end
    @(negedge clk_in);
  endtask

  task automatic run_job(input int n, input bit seq_w, input int wgap, input int amax,
                         input bit reuse, input bit feed_pulse);
    int a;
    logic [8:0] w;
    clear_mon();
    num_act_in = 8'(n);
    start_in   = 1'b1;
`ifdef FEED_CTRL_WEIGHT_REUSE_EN
    reuse_weight_in = reuse;
`endif
    @(negedge clk_in);
    start_in   = 1'b0;
    num_act_in = 8'($urandom);
    if (!reuse) begin
      for (int i = 0; i < O_CH; i++) begin
        w = seq_w ? 9'(i) : 9'($urandom);
        exp_w.push_back(w);
        push_word(w, wgap, a);
      end
    end
    for (int i = 0; i < n; i++) begin
      w = 9'($urandom);
      exp_a.push_back(w);
      push_word(w, $urandom_range(0, amax), a);
      acc_cyc.push_back(a);
      if (feed_pulse && i == 0) begin
        s_valid_in = 1'b0;
        start_in   = 1'b1;
        num_act_in = 8'd200;
        @(negedge clk_in);
        start_in   = 1'b0;
      end
    end
    // A word offered after feeding must not be taken.
    s_valid_in = 1'b1;
    s_data_in  = 9'h1A5;
    repeat (8) begin
      if (s_ready_out) viol++;
      @(negedge clk_in);
    end
    s_valid_in = 1'b0;
  endtask

  task automatic wait_done(input bit pop_pulse);
    int g;
    bit pulsed;
    g = 0;
    pulsed = 1'b0;
    while (done_cyc.size() == 0 && g < 5000) begin
      if (pop_pulse && !pulsed && pop_out) begin
        start_in   = 1'b1;
        num_act_in = 8'd7;
        pulsed     = 1'b1;
      end
      @(negedge clk_in);
      start_in = 1'b0;
      g++;
    end
    chk("done_seen", done_cyc.size() > 0, 1);
    repeat (4) @(negedge clk_in);
  endtask

  task automatic check_job(input bit load, input int n);
    int bad;
    int refc;
    chk("push_timeout", timeouts, 0);
    chk("lw_count", lw_cyc.size(), load ? O_CH : 0);
    if (load && lw_cyc.size() == O_CH) begin
      bad = 0;
      for (int i = 0; i < O_CH; i++) begin
        if (lw_dat[i] !== exp_w[i]) bad++;
        if (lw_cyc[i] != lw_cyc[0] + i) bad++;
      end
      chk("lw_order_gapfree", bad, 0);
    end
    chk("clear_count", clr_cyc.size(), 1);
    refc = (clr_cyc.size() > 0) ? clr_cyc[0] : -1000;
    if (load && lw_cyc.size() > 0 && clr_cyc.size() > 0)
      chk("clear_after_burst", clr_cyc[0], lw_cyc[lw_cyc.size()-1] + 1);
    chk("iv_count", iv_cyc.size(), n);
    bad = 0;
    for (int i = 0; i < n && i < iv_cyc.size(); i++) begin
      if (iv_dat[i] !== exp_a[i]) bad++;
      if (iv_cyc[i] != acc_cyc[i]) bad++;
      if (iv_cyc[i] <= refc) bad++;
    end
    chk("iv_data_latency", bad, 0);
    // Drain is measured from the last array activity of the job.
    if (iv_cyc.size() > 0) refc = iv_cyc[iv_cyc.size()-1];
    chk("pop_count", pop_cyc.size(), O_CH);
    if (pop_cyc.size() > 0) begin
      chk("pop_start", pop_cyc[0], refc + DRAIN + 1);
      bad = 0;
      for (int i = 0; i < pop_cyc.size(); i++)
        if (pop_cyc[i] != pop_cyc[0] + i) bad++;
      chk("pop_contiguous", bad, 0);
    end
    chk("m_count", mv_cyc.size(), O_CH);
    bad = 0;
    for (int i = 0; i < mv_cyc.size() && i < pop_cyc.size(); i++) begin
      if (mv_ch[i] != i) bad++;
      if (mv_sum[i] !== pop_sum[i]) bad++;
      if (mv_cyc[i] != pop_cyc[i] + 1) bad++;
    end
    chk("m_stream", bad, 0);
    chk("done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0 && pop_cyc.size() > 0)
      chk("done_at_end", done_cyc[0], pop_cyc[pop_cyc.size()-1] + 1);
    chk("protocol_viol", viol, 0);
    chk("idle_after", {busy_out, s_ready_out, done_out}, 0);
  endtask

  initial begin
    int g;
    int n;

    // Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_strobes", {s_ready_out, load_weight_out, in_valid_out, pop_out,
                        m_valid_out, busy_out, done_out, array_rst_n_out}, 0);
    chk("rst_data", {data_out, m_sum_out, m_ch_out}, 0);
    rst_in = 1'b0;
    #1;
    chk("arst_hold", array_rst_n_out, 0);
    @(negedge clk_in);
    chk("arst_release", array_rst_n_out, 1);
    repeat (2) @(negedge clk_in);

    // Sequential weights, three activations
    run_job(3, 1'b1, 0, 0, 1'b0, 1'b0);
    wait_done(1'b0);
    check_job(1'b1, 3);

    // Weight valid toggling every cycle, gappy activations
    run_job(5, 1'b0, 1, 3, 1'b0, 1'b0);
    wait_done(1'b0);
    check_job(1'b1, 5);

    // No activations
    run_job(0, 1'b0, 0, 0, 1'b0, 1'b0);
    wait_done(1'b0);
    check_job(1'b1, 0);

    // start_in pulsed during FEED and POP must be ignored
    run_job(4, 1'b0, 0, 2, 1'b0, 1'b1);
    wait_done(1'b1);
    check_job(1'b1, 4);
    repeat (5) @(negedge clk_in);
    chk("no_restart", {busy_out, done_cyc.size() == 1}, 1);

    // Reset during pop cycle 10
    run_job(2, 1'b0, 0, 1, 1'b0, 1'b0);
    g = 0;
    while (!pop_out && g < 3000) begin
      @(negedge clk_in);
      g++;
    end
    repeat (10) @(negedge clk_in);
    chk("pop10_active", pop_out, 1);
    rst_in = 1'b1;
    #1;
    chk("abort_strobes", {s_ready_out, load_weight_out, in_valid_out, pop_out,
                          m_valid_out, busy_out, done_out, array_rst_n_out}, 0);
    chk("abort_data", {data_out, m_sum_out, m_ch_out}, 0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("abort_arst_hold", array_rst_n_out, 0);
    @(negedge clk_in);
    chk("abort_arst_release", array_rst_n_out, 1);
    repeat (70) @(negedge clk_in);
    chk("abort_no_done", done_cyc.size(), 0);
    chk("abort_idle", {busy_out, pop_out, m_valid_out}, 0);

    // Fresh job after the abort
    run_job(6, 1'b0, 0, 2, 1'b0, 1'b0);
    wait_done(1'b0);
    check_job(1'b1, 6);

    // Random jobs
    for (int j = 0; j < 3; j++) begin
      n = $urandom_range(0, 12);
      run_job(n, 1'b0, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 1'b0);
      wait_done(1'b0);
      check_job(1'b1, n);
    end

`ifdef FEED_CTRL_WEIGHT_REUSE_EN
    // Weight reuse: the clear cycle is the first array activity
    run_job(3, 1'b0, 0, 1, 1'b1, 1'b0);
    wait_done(1'b0);
    check_job(1'b0, 3);
    reuse_weight_in = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bnn_feed_ctrl.md
BNN_FEED_CTRL -- requirements
Module: bnn_feed_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- O_CH, 64, output channels.
- OUT_ROW_LENGTH, 4, psum slots per channel.
- DRAIN_CYCLES, 66, cycles waited after the last activation.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_in  in  1  single clock.
- rst_in  in  1  reset, asynchronous, active-high.
- start_in  in  1  begin one layer-row job.
- num_act_in  in  8  activation beats for this job; latched at start.
- s_data_in  in  9  host weight/activation word.
- s_valid_in  in  1  host word valid.
- s_ready_out  out  1  word accepted when s_valid_in and s_ready_out are both 1.
- data_out  out  9  to array data input.
- load_weight_out  out  1  to array weight-load strobe.
- in_valid_out  out  1  to array activation-valid strobe.
- pop_out  out  1  to array pop strobe.
- array_rst_n_out  out  1  to array psum clear, active-low.
- array_sum_in  in  OUT_ROW_LENGTH  sign bits from the array.
- m_sum_out  out  OUT_ROW_LENGTH  captured sign bits.
- m_ch_out  out  6  channel index of m_sum_out.
- m_valid_out  out  1  m_sum_out/m_ch_out valid.
- busy_out  out  1  high whenever the FSM is not in IDLE.
- done_out  out  1  one-cycle pulse at job end.

Function
REQ-003 FSM states SHALL be IDLE, W_FILL, W_BURST, CLEAR, FEED, DRAIN, POP.
REQ-004 IDLE: start_in=1 SHALL latch num_act_in and go to W_FILL; start_in is ignored in every other state.
REQ-005 W_FILL: s_ready_out=1; each accepted word SHALL be written to weight buffer entry idx, idx=0..O_CH-1; after entry O_CH-1 is written, go to W_BURST.
REQ-006 W_BURST SHALL drive exactly O_CH consecutive cycles of load_weight_out=1 with data_out=buf[0..O_CH-1] in order, with no gaps, then go to CLEAR.
REQ-007 CLEAR SHALL drive array_rst_n_out=0 for exactly one cycle, then go to FEED, or to DRAIN if the latched num_act=0.
REQ-008 FEED: s_ready_out=1; each accepted word SHALL appear on data_out with in_valid_out=1 one cycle later; gaps in s_valid_in produce in_valid_out=0 cycles.
REQ-009 FEED SHALL leave for DRAIN after exactly num_act accepted words.
REQ-010 DRAIN SHALL last DRAIN_CYCLES cycles, counted from the cycle after the last in_valid_out=1, then go to POP.
REQ-011 POP SHALL drive pop_out=1 for exactly O_CH consecutive cycles, then go to IDLE, pulsing done_out one cycle on entry to IDLE.
REQ-012 During the k-th pop cycle (k=0..O_CH-1), array_sum_in SHALL be sampled.
REQ-013 On the cycle after the k-th pop cycle, m_valid_out=1, m_sum_out=sampled value and m_ch_out=k.
REQ-014 s_ready_out SHALL be 0 outside W_FILL and FEED; s_valid_in in those states SHALL be ignored and not consumed.
REQ-015 data_out SHALL be 0 whenever load_weight_out and in_valid_out are both 0.
REQ-016 load_weight_out, in_valid_out and pop_out SHALL be mutually exclusive.
REQ-017 All array-side outputs and m_* outputs SHALL be registered.
REQ-018 Counters SHALL not wrap within a job; idx and k SHALL return to 0 on entry to IDLE.

Reset
REQ-019 rst_in=1 SHALL asynchronously force:
- state to IDLE and all counters to 0;
- s_ready_out, load_weight_out, in_valid_out, pop_out, m_valid_out, busy_out, done_out, data_out, m_sum_out and m_ch_out to 0;
- array_rst_n_out to 0.
REQ-020 array_rst_n_out SHALL return to 1 on the first clock edge after rst_in deasserts.
REQ-021 Reset asserted mid-job SHALL abort the job with no done_out pulse; weight buffer contents are don't-care.

Configuration
REQ-022 Macro FEED_CTRL_WEIGHT_REUSE_EN defined SHALL add input port reuse_weight_in (1 bit, sampled with start_in).
REQ-023 With the macro defined, start_in with reuse_weight_in=1 SHALL go IDLE->CLEAR directly, skipping W_FILL and W_BURST; array weights are untouched.
REQ-024 With the macro undefined, the port SHALL not exist and every job SHALL load weights.

Verification
REQ-025 Reset, then start with num_act=3: 64 weights 0x000..0x03F, then 3 activations -> 64 contiguous load_weight_out cycles in order, one clear cycle, 3 in_valid_out, 66 drain cycles, 64 pops, 64 m_valid_out with m_ch_out 0..63, one done_out.
REQ-026 s_valid_in toggling 1/0 during W_FILL -> W_BURST still 64 gap-free cycles with correct order.
REQ-027 num_act=0 -> no in_valid_out; CLEAR goes to DRAIN, then 64 pops.
REQ-028 start_in pulsed during FEED and POP -> ignored; the job completes once.
REQ-029 rst_in asserted on pop cycle 10 -> all strobes 0 immediately, no done_out; a fresh job then runs normally.
REQ-030 With FEED_CTRL_WEIGHT_REUSE_EN and reuse_weight_in=1 -> no load_weight_out cycles; the first output activity is the clear cycle.
